// File: rtl/booth_seq_ctrl_pkg.sv
// Shared constants and FSM state type for the sequential radix-2 Booth multiplier.
package booth_seq_ctrl_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned P_W   = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_seq_ctrl_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// right shift of {ACC,Q,q_1}. Purely combinational.
module booth_iter_step
  import booth_seq_ctrl_pkg::*;
(
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic             w_add;
  logic             w_sub;
  logic [WIDTH:0]   w_opnd;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sel;
  logic             w_carry;

  assign w_add  = ~i_q[0] & i_q1;
  assign w_sub  = i_q[0] & ~i_q1;
  assign w_opnd = w_sub ? ~i_m : i_m;

  // Ripple adder/subtractor; subtraction is add of ~M with carry-in 1.
  always_comb begin
    w_sum   = '0;
    w_carry = w_sub;
    for (int unsigned i = 0; i < WIDTH + 1; i++) begin
      w_sum[i] = i_acc[i] ^ w_opnd[i] ^ w_carry;
      w_carry  = (i_acc[i] & w_opnd[i]) | (w_carry & (i_acc[i] ^ w_opnd[i]));
    end
  end

  assign w_sel = (w_add | w_sub) ? w_sum : i_acc;

  assign o_acc = {w_sel[WIDTH], w_sel[WIDTH:1]};
  assign o_q   = {w_sel[0], i_q[WIDTH-1:1]};
  assign o_q1  = i_q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed WIDTHxWIDTH Booth multiplier: one iteration per clock,
// valid/ready on both operand input and product output.
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [P_W-1:0]   o_p,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_p;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q1_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;

  assign w_accept = (r_state == ST_IDLE) && i_in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  booth_iter_step u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_q1  (w_q1_nxt)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_in_valid)  w_next_state = ST_RUN;
      ST_RUN:  if (w_last)      w_next_state = ST_DONE;
      ST_DONE: if (i_out_ready) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags are registered with it
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    case (w_next_state)
      ST_IDLE: w_in_ready_nxt  = 1'b1;
      ST_RUN:  w_busy_nxt      = 1'b1;
      ST_DONE: w_out_valid_nxt = 1'b1;
      default: w_in_ready_nxt  = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Operand load, iteration datapath and product capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_m   <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_q1  <= 1'b0;
      r_m   <= {i_b[WIDTH-1], i_b};
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= w_q1_nxt;
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) r_p <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_p         = r_p;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and randomised self-checking bench for booth_seq_ctrl.
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_p         (p),
    .o_busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair, wait (bounded) for acceptance, then scramble A/B.
  task automatic start_pair(input logic [15:0] ta, input logic [15:0] tb_v);
    int c;
    c = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    while (!in_ready && c < 100) begin
      step();
      c++;
    end
    step();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (p !== 32'h0) begin n_err++; $display("FAIL reset_p got=%h exp=0", p); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_hold got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int cyc;
    out_ready = 1'b1;
    start_pair(16'd3, 16'd5);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_run busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_valid(cyc);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL basic_latency got=%0d exp=16", cyc); end
    n_cmp++; if (p !== 32'd15) begin n_err++; $display("FAIL basic_p got=%0d exp=15", p); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_handshake in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_signs();
    int cyc;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    va[0] = -16'sd7; vb[0] = 16'sd6;
    va[1] = 16'sd6;  vb[1] = -16'sd7;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_pair(va[i], vb[i]);
      wait_valid(cyc);
      n_cmp++; if (p !== 32'hFFFF_FFD6) begin n_err++; $display("FAIL signs_%0d got=%h exp=ffffffd6", i, p); end
      step();
    end
  endtask

  task automatic test_extremes();
    int cyc;
    out_ready = 1'b1;
    start_pair(16'h8000, 16'h8000);
    wait_valid(cyc);
    n_cmp++; if (p !== 32'h4000_0000) begin n_err++; $display("FAIL ext_minmin got=%h exp=40000000", p); end
    step();
    start_pair(16'h7FFF, 16'h8000);
    wait_valid(cyc);
    n_cmp++; if (p !== 32'hC000_8000) begin n_err++; $display("FAIL ext_maxmin got=%h exp=c0008000", p); end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    start_pair(16'd1234, -16'sd3);
    wait_valid(cyc);
    n_cmp++; if (p !== 32'hFFFF_F18A) begin n_err++; $display("FAIL bp_p got=%h exp=fffff18a", p); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; a = 16'd7; b = 16'd7; end
      if (i == 4) in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || p !== 32'hFFFF_F18A || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d out_valid=%b p=%h in_ready=%b exp 1/fffff18a/0", i, out_valid, p, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    step();
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_not_queued in_ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    out_ready = 1'b1;
    start_pair(16'd100, 16'd200);
    for (int i = 0; i < 7; i++) step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset in_ready=%b out_valid=%b busy=%b p=%h exp 1/0/0/0", in_ready, out_valid, busy, p);
    end
    rst_n = 1'b1;
    start_pair(16'd100, 16'd200);
    wait_valid(cyc);
    n_cmp++; if (cyc !== 16) begin n_err++; $display("FAIL mid_latency got=%0d exp=16", cyc); end
    n_cmp++; if (p !== 32'd20000) begin n_err++; $display("FAIL mid_p got=%0d exp=20000", p); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0]        ra;
    logic [15:0]        rb;
    logic signed [31:0] ea;
    logic signed [31:0] eb;
    logic [31:0]        exp_p;
    bit                 done;
    int                 c;
    for (int n = 0; n < 50; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ea = $signed(ra);
      eb = $signed(rb);
      exp_p = 32'(ea * eb);
      start_pair(ra, rb);
      done = 1'b0;
      c = 0;
      while (!done && c < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          n_cmp++;
          if (p !== exp_p) begin n_err++; $display("FAIL b2b_%0d a=%h b=%h got=%h exp=%h", n, ra, rb, p, exp_p); end
          done = 1'b1;
        end
        step();
        c++;
      end
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_timeout_%0d got=no_product exp=product", n);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequential signed multiplier controller. It time-multiplexes a single radix-2 Booth iteration step over WIDTH clock cycles instead of unrolling WIDTH stages. It accepts operand pairs on a valid/ready input handshake and returns the registered 2·WIDTH-bit product on a valid/ready output handshake. It serves as the area-reduced alternative to the unrolled 16x16 signed multiplier in the arithmetic library.

## Interface
- WIDTH, 16: operand width; product is 2·WIDTH bits.
- CLK  in  1  single clock; all state updates on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_VALID  in  1  operand pair on A/B is valid.
- IN_READY  out  1  block can accept an operand pair.
- A  in  WIDTH  signed multiplier (Booth-scanned operand).
- B  in  WIDTH  signed multiplicand.
- OUT_VALID  out  1  P holds a finished product.
- OUT_READY  in  1  consumer accepts P.
- P  out  2·WIDTH  signed product A·B.
- BUSY  out  1  high in RUN state.

## Operation
- FSM states:
  - IDLE → RUN on IN_VALID && IN_READY.
  - RUN → DONE when the step counter reaches WIDTH−1 and that step completes.
  - DONE → IDLE on OUT_VALID && OUT_READY.
- IN_READY = (state == IDLE). OUT_VALID = (state == DONE). BUSY = (state == RUN).
- Load happens in IDLE on the accept edge:
  - ACC (WIDTH+1 bits) ← 0.
  - Q ← A.
  - q_1 ← 0.
  - M ← B sign-extended to WIDTH+1 bits.
  - counter ← 0.
- Each RUN cycle performs one step:
  - {Q[0],q_1} = 01 → ACC+M; 10 → ACC−M; 00/11 → ACC unchanged.
  - Then arithmetic right shift of {ACC,Q,q_1} by one, with the ACC MSB replicated.
  - Counter increments, 4 bits for WIDTH=16, wrapping at WIDTH.
- ACC is WIDTH+1 bits so that B = −2^(WIDTH−1) does not overflow on subtraction.
- P = {ACC[WIDTH−1:0], Q}, registered. P holds stable through DONE until the handshake completes.
- A/B are sampled only on the accept edge. Changes afterwards have no effect.
- IN_VALID asserted outside IDLE is ignored (not queued).

## Timing
- Reset values: state IDLE, IN_READY 1, OUT_VALID 0, BUSY 0, P 0, ACC 0, Q 0, q_1 0, counter 0.
- Latency: accept at edge k. Steps at edges k+1..k+WIDTH. OUT_VALID is high from edge k+WIDTH, i.e. 16 cycles after accept for WIDTH=16.
- Throughput: one product per WIDTH+2 cycles when OUT_READY is held high. The DONE→IDLE cycle and the IDLE accept cycle are not overlapped.
- Backpressure: OUT_READY low in DONE holds OUT_VALID, P and state indefinitely.
- RST_N low on any edge overrides all other events, including mid-RUN and during DONE. The in-flight product is discarded and all outputs take reset values on that edge.
- IN_VALID and OUT_READY in the same cycle are independent. Only one is meaningful per state.

## Structure
- Shared arithmetic package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the WIDTH-derived counter width constant, clog2(WIDTH).
- Sub-module booth_iter_step: purely combinational. Inputs ACC, Q, q_1, M; outputs next ACC, Q, q_1. Built on the library ripple adder/subtractor cells widened to WIDTH+1.
- Top holds the FSM, counter, operand registers and the output register.

## Test plan
- A=3, B=5, OUT_READY=1: accept → OUT_VALID high exactly 16 cycles later with P=15, then IN_READY returns after the handshake.
- A=−7, B=6, then A=6, B=−7: P=−42 (0xFFFFFFD6) for both.
- Extremes:
  - A=B=−32768 → P=1073741824 (0x40000000).
  - A=32767, B=−32768 → P=−1073709056.
- Hold OUT_READY=0 for 10 cycles after OUT_VALID rises: P and OUT_VALID stable, IN_READY=0, and a new IN_VALID pulse is ignored. Release → next cycle IDLE.
- Drop RST_N for one cycle at step 8 of A=100, B=200: next edge IDLE, all outputs at reset values. A fresh A=100, B=200 yields P=20000 after 16 cycles.
- Back-to-back: 50 random signed pairs with random OUT_READY stalls. Every P equals the reference product, in order.
